// File: rtl/udma_hyper_ch_sched.sv
// Round-robin scheduler sharing one HyperBus PHY transaction engine among
// NB_CH uDMA channels. One descriptor is accepted, issued to the PHY, awaited,
// and closed with a one-cycle EOT pulse on the owning channel.
module udma_hyper_ch_sched #(
  parameter int NB_CH      = 8,
  parameter int TRANS_SIZE = 16,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                          sys_clk_i,
  input  logic                          rst_i,
  input  logic [NB_CH-1:0]              ch_en_i,
  input  logic [NB_CH-1:0]              req_valid_i,
  output logic [NB_CH-1:0]              req_ready_o,
  input  logic [NB_CH-1:0]              req_rwn_i,
  input  logic [NB_CH*ADDR_WIDTH-1:0]   req_addr_i,
  input  logic [NB_CH*TRANS_SIZE-1:0]   req_len_i,
  input  logic                          abort_i,
  output logic                          trans_valid_o,
  input  logic                          trans_ready_i,
  output logic                          trans_rwn_o,
  output logic [ADDR_WIDTH-1:0]         trans_addr_o,
  output logic [TRANS_SIZE-1:0]         trans_len_o,
  input  logic                          trans_done_i,
  output logic [NB_CH-1:0]              evt_eot_o,
  output logic                          busy_o,
  output logic [$clog2(NB_CH)-1:0]      cur_ch_o
);

  localparam int CW = $clog2(NB_CH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_BUSY  = 2'd2,
    ST_EOT   = 2'd3
  } state_e;

  state_e                 state_r;
  state_e                 state_next_s;

  logic [NB_CH-1:0]       elig_s;
  logic                   win_found_s;
  logic [CW-1:0]          win_idx_s;
  logic [TRANS_SIZE-1:0]  win_len_s;
  int                     idx_v;

  logic                   grant_s;
  logic                   rr_adv_s;
  logic [CW-1:0]          ptr_after_s;
  logic [CW-1:0]          eot_ch_s;
  logic [NB_CH-1:0]       req_ready_s;

  logic [CW-1:0]          rr_ptr_r;
  logic [CW-1:0]          cur_ch_r;
  logic                   trans_valid_r;
  logic                   trans_rwn_r;
  logic [ADDR_WIDTH-1:0]  trans_addr_r;
  logic [TRANS_SIZE-1:0]  trans_len_r;
  logic [NB_CH-1:0]       evt_eot_r;
  logic                   busy_r;

  function automatic logic [NB_CH-1:0] ch_onehot(input logic [CW-1:0] ch);
    ch_onehot = {{(NB_CH-1){1'b0}}, 1'b1} << ch;
  endfunction

  // Find the first eligible channel at or after rr_ptr_r, wrapping around
  always_comb begin
    elig_s      = req_valid_i & ch_en_i;
    win_found_s = 1'b0;
    win_idx_s   = '0;
    idx_v       = 0;
    for (int i = 0; i < NB_CH; i++) begin
      idx_v = int'(rr_ptr_r) + i;
      idx_v = (idx_v >= NB_CH) ? (idx_v - NB_CH) : idx_v;
      if (!win_found_s && elig_s[idx_v[CW-1:0]]) begin
        win_found_s = 1'b1;
        win_idx_s   = idx_v[CW-1:0];
      end else begin
        win_found_s = win_found_s;
      end
    end
    win_len_s = req_len_i[win_idx_s*TRANS_SIZE +: TRANS_SIZE];
  end

  // State register
  always_ff @(posedge sys_clk_i) begin
    if (rst_i) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic; abort takes priority over ready/done
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (win_found_s) begin
          state_next_s = (win_len_s == '0) ? ST_EOT : ST_ISSUE;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (abort_i) begin
          state_next_s = ST_IDLE;
        end else if (trans_ready_i) begin
          state_next_s = ST_BUSY;
        end else begin
          state_next_s = ST_ISSUE;
        end
      end
      ST_BUSY: begin
        if (abort_i) begin
          state_next_s = ST_IDLE;
        end else if (trans_done_i) begin
          state_next_s = ST_EOT;
        end else begin
          state_next_s = ST_BUSY;
        end
      end
      ST_EOT:  state_next_s = ST_IDLE;
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Output decode: grant strobe, pointer advance and EOT target channel
  always_comb begin
    grant_s     = (state_r == ST_IDLE) && win_found_s && !rst_i;
    req_ready_s = grant_s ? ch_onehot(win_idx_s) : '0;
    rr_adv_s    = (state_r == ST_EOT) ||
                  (((state_r == ST_ISSUE) || (state_r == ST_BUSY)) && abort_i);
    ptr_after_s = (cur_ch_r == CW'(NB_CH - 1)) ? '0 : (cur_ch_r + CW'(1));
    eot_ch_s    = (state_r == ST_IDLE) ? win_idx_s : cur_ch_r;
  end

  // Registered outputs, descriptor latch and round-robin pointer
  always_ff @(posedge sys_clk_i) begin
    if (rst_i) begin
      trans_valid_r <= 1'b0;
      busy_r        <= 1'b0;
      evt_eot_r     <= '0;
      trans_rwn_r   <= 1'b0;
      trans_addr_r  <= '0;
      trans_len_r   <= '0;
      cur_ch_r      <= '0;
      rr_ptr_r      <= '0;
    end else begin
      trans_valid_r <= (state_next_s == ST_ISSUE);
      busy_r        <= (state_next_s != ST_IDLE);
      evt_eot_r     <= (state_next_s == ST_EOT) ? ch_onehot(eot_ch_s) : '0;
      if (grant_s) begin
        trans_rwn_r  <= req_rwn_i[win_idx_s];
        trans_addr_r <= req_addr_i[win_idx_s*ADDR_WIDTH +: ADDR_WIDTH];
        trans_len_r  <= win_len_s;
        cur_ch_r     <= win_idx_s;
      end
      if (rr_adv_s) begin
        rr_ptr_r <= ptr_after_s;
      end
    end
  end

  assign req_ready_o   = req_ready_s;
  assign trans_valid_o = trans_valid_r;
  assign trans_rwn_o   = trans_rwn_r;
  assign trans_addr_o  = trans_addr_r;
  assign trans_len_o   = trans_len_r;
  assign evt_eot_o     = evt_eot_r;
  assign busy_o        = busy_r;
  assign cur_ch_o      = cur_ch_r;

endmodule

// File: tb/tb_udma_hyper_ch_sched.sv
// Bench for udma_hyper_ch_sched: directed scenarios followed by random traffic,
// every cycle compared against a transaction-level reference model.
module tb_udma_hyper_ch_sched;

  localparam int NB = 8;
  localparam int TS = 16;
  localparam int AW = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic [NB-1:0]     ch_en, req_valid, req_ready, req_rwn, evt_eot;
  logic [NB*AW-1:0]  req_addr;
  logic [NB*TS-1:0]  req_len;
  logic              abort, trans_valid, trans_ready, trans_rwn, trans_done, busy;
  logic [AW-1:0]     trans_addr;
  logic [TS-1:0]     trans_len;
  logic [2:0]        cur_ch;

  udma_hyper_ch_sched #(.NB_CH(NB), .TRANS_SIZE(TS), .ADDR_WIDTH(AW)) dut (
    .sys_clk_i(clk), .rst_i(rst), .ch_en_i(ch_en), .req_valid_i(req_valid),
    .req_ready_o(req_ready), .req_rwn_i(req_rwn), .req_addr_i(req_addr),
    .req_len_i(req_len), .abort_i(abort), .trans_valid_o(trans_valid),
    .trans_ready_i(trans_ready), .trans_rwn_o(trans_rwn), .trans_addr_o(trans_addr),
    .trans_len_o(trans_len), .trans_done_i(trans_done), .evt_eot_o(evt_eot),
    .busy_o(busy), .cur_ch_o(cur_ch)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int grant_q[$];

  // Reference model: where the single outstanding transaction stands
  // (0 none, 1 offered to PHY, 2 PHY working, 3 completion being signalled).
  int              m_phase, m_ptr, m_ch;
  logic            m_rwn;
  logic [AW-1:0]   m_addr;
  logic [TS-1:0]   m_len;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int m_winner();
    for (int i = 0; i < NB; i++) begin
      int k;
      k = (m_ptr + i) % NB;
      if (req_valid[k] && ch_en[k]) return k;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_ptr = 0; m_ch = 0; m_rwn = 1'b0; m_addr = '0; m_len = '0;
  endtask

  task automatic model_step();
    int w;
    if (rst) begin
      model_reset();
    end else begin
      case (m_phase)
        0: begin
          w = m_winner();
          if (w >= 0) begin
            m_ch   = w;
            m_rwn  = req_rwn[w];
            m_addr = req_addr[w*AW +: AW];
            m_len  = req_len[w*TS +: TS];
            m_phase = (m_len == 0) ? 3 : 1;
          end
        end
        1: begin
          if (abort) begin m_phase = 0; m_ptr = (m_ch + 1) % NB; end
          else if (trans_ready) m_phase = 2;
        end
        2: begin
          if (abort) begin m_phase = 0; m_ptr = (m_ch + 1) % NB; end
          else if (trans_done) m_phase = 3;
        end
        default: begin m_phase = 0; m_ptr = (m_ch + 1) % NB; end
      endcase
    end
  endtask

  // One clock: compare outputs mid-cycle, then advance the model at the edge
  task automatic run_cycle();
    logic [NB-1:0] exp_rdy, exp_eot;
    int w;
    @(negedge clk);
    w = m_winner();
    exp_rdy = (!rst && m_phase == 0 && w >= 0) ? (NB'(1) << w) : '0;
    exp_eot = (m_phase == 3) ? (NB'(1) << m_ch) : '0;
    check_val("req_ready", 64'(req_ready), 64'(exp_rdy));
    check_val("trans_valid", 64'(trans_valid), 64'(m_phase == 1));
    check_val("trans_rwn", 64'(trans_rwn), 64'(m_rwn));
    check_val("trans_addr", 64'(trans_addr), 64'(m_addr));
    check_val("trans_len", 64'(trans_len), 64'(m_len));
    check_val("evt_eot", 64'(evt_eot), 64'(exp_eot));
    check_val("busy", 64'(busy), 64'(m_phase != 0));
    check_val("cur_ch", 64'(cur_ch), 64'(m_ch));
    for (int k = 0; k < NB; k++) if (req_ready[k]) grant_q.push_back(k);
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic check_grants(input string tag, input int exp0, input int exp1);
    check_val({tag, "_cnt_ok"}, 64'(grant_q.size() >= 2), 64'd1);
    if (grant_q.size() >= 2) begin
      check_val({tag, "_g0"}, 64'(grant_q[0]), 64'(exp0));
      check_val({tag, "_g1"}, 64'(grant_q[1]), 64'(exp1));
    end
  endtask

  initial begin
    int ch4_hits;
    rst = 1'b1; ch_en = '1; req_valid = '0; req_rwn = '0; req_addr = '0; req_len = '0;
    abort = 1'b0; trans_ready = 1'b0; trans_done = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    run_cycle();
    rst = 1'b0;

    // Single transfer on ch2
    req_valid = 8'h04; req_rwn = 8'h04;
    req_addr[2*AW +: AW] = 32'h0000_1000; req_len[2*TS +: TS] = 16'd64;
    trans_ready = 1'b1; trans_done = 1'b1;
    run_cycle();
    req_valid = '0;
    repeat (5) run_cycle();

    // Round robin 0,3,7,0,3 with wrap after ch7
    rst = 1'b1; run_cycle(); rst = 1'b0;
    for (int k = 0; k < NB; k++) req_len[k*TS +: TS] = TS'(k + 1);
    req_valid = 8'h89; grant_q.delete();
    repeat (20) run_cycle();
    req_valid = '0;
    check_val("rr_cnt_ok", 64'(grant_q.size() >= 5), 64'd1);
    if (grant_q.size() >= 5) begin
      check_val("rr_g0", 64'(grant_q[0]), 64'd0);
      check_val("rr_g1", 64'(grant_q[1]), 64'd3);
      check_val("rr_g2", 64'(grant_q[2]), 64'd7);
      check_val("rr_g3", 64'(grant_q[3]), 64'd0);
      check_val("rr_g4", 64'(grant_q[4]), 64'd3);
    end
    repeat (4) run_cycle();

    // Mask: ch4 disabled never gets ready
    req_valid = 8'h12; ch_en = 8'hEF; grant_q.delete();
    repeat (16) run_cycle();
    ch4_hits = 0;
    foreach (grant_q[i]) if (grant_q[i] == 4) ch4_hits++;
    check_val("mask_ch4_hits", 64'(ch4_hits), 64'd0);
    check_val("mask_ch1_seen", 64'(grant_q.size() > 0), 64'd1);
    req_valid = '0; ch_en = '1;
    repeat (4) run_cycle();

    // Zero length on ch5
    req_len[5*TS +: TS] = '0; req_valid = 8'h20;
    run_cycle();
    req_valid = '0;
    repeat (4) run_cycle();

    // Abort in BUSY on ch6, ch7 pending
    req_valid = 8'hC0; trans_done = 1'b0; grant_q.delete();
    run_cycle(); run_cycle();
    abort = 1'b1; run_cycle(); abort = 1'b0;
    run_cycle();
    req_valid = '0;
    check_grants("abort", 6, 7);
    trans_done = 1'b1;
    repeat (4) run_cycle();

    // Reset while offering with trans_ready held low
    trans_ready = 1'b0; req_valid = 8'h20;
    run_cycle(); run_cycle();
    rst = 1'b1; run_cycle(); rst = 1'b0;
    req_valid = 8'h21; grant_q.delete();
    run_cycle();
    req_valid = '0; trans_ready = 1'b1;
    repeat (4) run_cycle();
    check_val("rst_next_grant_ok", 64'(grant_q.size() >= 1), 64'd1);
    if (grant_q.size() >= 1) check_val("rst_next_grant", 64'(grant_q[0]), 64'd0);

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      rst         = ($urandom_range(0, 99) < 2);
      ch_en       = ($urandom_range(0, 3) == 0) ? NB'($urandom) : '1;
      req_valid   = NB'($urandom);
      req_rwn     = NB'($urandom);
      for (int k = 0; k < NB; k++) begin
        req_addr[k*AW +: AW] = $urandom;
        req_len[k*TS +: TS]  = ($urandom_range(0, 7) == 0) ? '0 : TS'($urandom_range(1, 255));
      end
      abort       = ($urandom_range(0, 19) == 0);
      trans_ready = ($urandom_range(0, 1) == 1);
      trans_done  = ($urandom_range(0, 2) == 0);
      run_cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
